// File: rtl/conv_out_reader_if.sv
// Frame-in / pixel-out bus of the convolution output reader.
// The reader itself connects through the slave modport; its environment connects through master.
interface conv_out_reader_if #(
    parameter int PIX_W = 2,
    parameter int ROWS  = 10,
    parameter int COLS  = 10
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic                        frame_valid;
    logic                        frame_ready;
    logic [ROWS*COLS*PIX_W-1:0]  frame_data;
    logic                        m_valid;
    logic                        m_ready;
    logic [PIX_W-1:0]            m_data;
    logic [RW-1:0]               m_row;
    logic [CW-1:0]               m_col;
    logic                        m_last_col;
    logic                        m_last_frame;
    logic                        busy;

    modport slave (
        input  frame_valid, frame_data, m_ready,
        output frame_ready, m_valid, m_data, m_row, m_col,
               m_last_col, m_last_frame, busy
    );

    modport master (
        output frame_valid, frame_data, m_ready,
        input  frame_ready, m_valid, m_data, m_row, m_col,
               m_last_col, m_last_frame, busy
    );
endinterface

// File: rtl/conv_out_reader.sv
// Buffers one result frame and streams it out pixel by pixel in row-major order.
//   state  | meaning
//   IDLE   | no frame held; frame_ready high once out of reset
//   STREAM | frame buffered; presenting pixel (row,col) on the m_* side
module conv_out_reader #(
    parameter int PIX_W = 2,
    parameter int ROWS  = 10,
    parameter int COLS  = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    conv_out_reader_if.slave    bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t            state_q, state_d;
    logic              ready_en_q;
    logic [PIX_W-1:0]  pix_q [ROWS][COLS];
    logic [RW-1:0]     row_q;
    logic [CW-1:0]     col_q;
    logic              load, adv;
    logic              last_col, last_pix, streaming;

    assign last_col  = (col_q == CW'(COLS - 1));
    assign last_pix  = last_col && (row_q == RW'(ROWS - 1));
    assign streaming = (state_q == STREAM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        adv     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.frame_valid && ready_en_q) begin
                    load    = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (bus.m_ready) begin
                    adv = 1'b1;
                    if (last_pix) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ready_en_q keeps frame_ready low until the first clock edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    pix_q[r][c] <= '0;
                end
            end
        end else begin
            ready_en_q <= 1'b1;
            if (load) begin
                row_q <= '0;
                col_q <= '0;
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        pix_q[r][c] <= bus.frame_data[PIX_W*(COLS*r+c) +: PIX_W];
                    end
                end
            end else if (adv) begin
                if (last_col) begin
                    col_q <= '0;
                    row_q <= last_pix ? '0 : row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end

    assign bus.frame_ready  = (state_q == IDLE) && ready_en_q;
    assign bus.m_valid      = streaming;
    assign bus.busy         = streaming;
    assign bus.m_data       = streaming ? pix_q[row_q][col_q] : '0;
    assign bus.m_row        = streaming ? row_q : '0;
    assign bus.m_col        = streaming ? col_q : '0;
    assign bus.m_last_col   = streaming && last_col;
    assign bus.m_last_frame = streaming && last_pix;
endmodule

// File: tb/tb_conv_out_reader.sv
// Randomized bench for conv_out_reader: each pixel is compared with an image
// array indexed by its position in row-major output order.
module tb_conv_out_reader;
    localparam int PIX_W = 2;
    localparam int ROWS  = 10;
    localparam int COLS  = 10;
    localparam int NPIX  = ROWS * COLS;
    localparam int S_PW  = 4;
    localparam int S_R   = 3;
    localparam int S_C   = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_out_reader_if #(.PIX_W(PIX_W), .ROWS(ROWS), .COLS(COLS)) bus ();
    conv_out_reader_if #(.PIX_W(S_PW), .ROWS(S_R), .COLS(S_C)) bus_s ();

    conv_out_reader #(.PIX_W(PIX_W), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    conv_out_reader #(.PIX_W(S_PW), .ROWS(S_R), .COLS(S_C)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bus_s)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int img   [ROWS][COLS];
    int img_s [S_R][S_C];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [NPIX*PIX_W-1:0] pack_img();
        logic [NPIX*PIX_W-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                v[PIX_W*(COLS*r+c) +: PIX_W] = PIX_W'(img[r][c]);
        return v;
    endfunction

    function automatic logic [S_R*S_C*S_PW-1:0] pack_img_s();
        logic [S_R*S_C*S_PW-1:0] v;
        v = '0;
        for (int r = 0; r < S_R; r++)
            for (int c = 0; c < S_C; c++)
                v[S_PW*(S_C*r+c) +: S_PW] = S_PW'(img_s[r][c]);
        return v;
    endfunction

    task automatic fill_img(input int mode, input int val);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                case (mode)
                    0:       img[r][c] = (r + c) % 4;
                    1:       img[r][c] = val;
                    default: img[r][c] = $urandom_range(0, 3);
                endcase
    endtask

    // Called at a negedge; returns at the negedge right after the handshake.
    task automatic send_frame(input logic [NPIX*PIX_W-1:0] fd, input bit hold, input string tag);
        int cyc;
        cyc = 0;
        bus.frame_data  = fd;
        bus.frame_valid = 1'b1;
        while (!bus.frame_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "/accept"}, 32'(bus.frame_ready), 32'd1);
        @(negedge clk);
        if (!hold) bus.frame_valid = 1'b0;
        check({tag, "/latency"}, 32'(bus.m_valid), 32'd1);
        check({tag, "/busy"}, 32'(bus.busy), 32'd1);
        check({tag, "/fr_low"}, 32'(bus.frame_ready), 32'd0);
    endtask

    // Accepts n pixels; rnd selects ~50% random m_ready, else m_ready held high.
    task automatic drain(input int n, input bit rnd, input string tag);
        int k, cyc, r, c;
        bit stalled, started;
        logic [31:0] held, cur;
        k = 0; cyc = 0; stalled = 0; started = 0; held = '0;
        while (k < n && cyc < 2000) begin
            bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.m_valid) begin
                cur = 32'({bus.m_data, bus.m_row, bus.m_col, bus.m_last_col, bus.m_last_frame});
                if (stalled) check({tag, "/stall_hold"}, cur, held);
                started = 1;
                if (bus.m_ready) begin
                    r = k / COLS;
                    c = k % COLS;
                    check({tag, "/data"}, 32'(bus.m_data), 32'(img[r][c]));
                    check({tag, "/row"}, 32'(bus.m_row), 32'(r));
                    check({tag, "/col"}, 32'(bus.m_col), 32'(c));
                    check({tag, "/last_col"}, 32'(bus.m_last_col), 32'(c == COLS - 1));
                    check({tag, "/last_frame"}, 32'(bus.m_last_frame), 32'(k == NPIX - 1));
                    k++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = cur;
                end
            end else if (started && !rnd) begin
                check({tag, "/gap"}, 32'(bus.m_valid), 32'd1);
            end
            @(negedge clk);
            cyc++;
        end
        bus.m_ready = 1'b0;
        check({tag, "/count"}, 32'(k), 32'(n));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "/idle_valid"}, 32'(bus.m_valid), 32'd0);
        check({tag, "/idle_ready"}, 32'(bus.frame_ready), 32'd1);
        check({tag, "/idle_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "/idle_out"},
              32'({bus.m_data, bus.m_row, bus.m_col, bus.m_last_col, bus.m_last_frame}), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NPIX*PIX_W-1:0] fd1, fd3;
        int k, cyc;

        bus.frame_valid = 1'b0; bus.frame_data = '0; bus.m_ready = 1'b0;
        bus_s.frame_valid = 1'b0; bus_s.frame_data = '0; bus_s.m_ready = 1'b0;

        #12;
        check("rst/valid", 32'(bus.m_valid), 32'd0);
        check("rst/frame_ready", 32'(bus.frame_ready), 32'd0);
        check("rst/busy", 32'(bus.busy), 32'd0);
        check("rst/data", 32'(bus.m_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel/ready_before_edge", 32'(bus.frame_ready), 32'd0);
        @(negedge clk);
        check("rel/ready_after_edge", 32'(bus.frame_ready), 32'd1);

        // m_ready in IDLE must not disturb anything
        bus.m_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle("idle_mready");
        end
        bus.m_ready = 1'b0;

        fill_img(0, 0);
        send_frame(pack_img(), 0, "diag_full");
        drain(NPIX, 0, "diag_full");
        check_idle("diag_full");

        send_frame(pack_img(), 0, "diag_rand");
        drain(NPIX, 1, "diag_rand");
        check_idle("diag_rand");

        // second frame offered during streaming is ignored until IDLE
        fill_img(1, 3); fd3 = pack_img();
        fill_img(1, 1); fd1 = pack_img();
        send_frame(fd1, 1, "ovl_a");
        bus.frame_data = fd3;
        drain(NPIX, 0, "ovl_a");
        check("ovl/idle_ready", 32'(bus.frame_ready), 32'd1);
        check("ovl/idle_valid", 32'(bus.m_valid), 32'd0);
        @(negedge clk);
        bus.frame_valid = 1'b0;
        check("ovl_b/latency", 32'(bus.m_valid), 32'd1);
        fill_img(1, 3);
        drain(NPIX, 0, "ovl_b");
        check_idle("ovl_b");

        fill_img(1, 0);
        img[4][7] = 2;
        send_frame(pack_img(), 0, "single");
        drain(NPIX, 1, "single");
        check_idle("single");

        // reset mid-frame
        fill_img(2, 0);
        send_frame(pack_img(), 0, "midrst");
        drain(37, 1, "midrst");
        rst_n = 1'b0;
        #1;
        check("midrst/valid", 32'(bus.m_valid), 32'd0);
        check("midrst/busy", 32'(bus.busy), 32'd0);
        check("midrst/frame_ready", 32'(bus.frame_ready), 32'd0);
        check("midrst/out",
              32'({bus.m_data, bus.m_row, bus.m_col, bus.m_last_col, bus.m_last_frame}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("midrst_rel");
        fill_img(2, 0);
        send_frame(pack_img(), 0, "postrst");
        drain(NPIX, 1, "postrst");
        check_idle("postrst");

        for (int f = 0; f < 3; f++) begin
            fill_img(2, 0);
            send_frame(pack_img(), 0, "rand");
            drain(NPIX, (f != 1), "rand");
            check_idle("rand");
        end

        // small instance: 3x5 frame of 4-bit pixels, m_ready high
        for (int r = 0; r < S_R; r++)
            for (int c = 0; c < S_C; c++)
                img_s[r][c] = $urandom_range(0, 15);
        bus_s.frame_data  = pack_img_s();
        bus_s.frame_valid = 1'b1;
        cyc = 0;
        while (!bus_s.frame_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("small/accept", 32'(bus_s.frame_ready), 32'd1);
        @(negedge clk);
        bus_s.frame_valid = 1'b0;
        bus_s.m_ready = 1'b1;
        k = 0;
        cyc = 0;
        while (k < S_R * S_C && cyc < 100) begin
            if (bus_s.m_valid) begin
                check("small/data", 32'(bus_s.m_data), 32'(img_s[k / S_C][k % S_C]));
                check("small/row", 32'(bus_s.m_row), 32'(k / S_C));
                check("small/col", 32'(bus_s.m_col), 32'(k % S_C));
                check("small/last_col", 32'(bus_s.m_last_col), 32'((k % S_C) == S_C - 1));
                check("small/last_frame", 32'(bus_s.m_last_frame), 32'(k == S_R * S_C - 1));
                k++;
            end else begin
                check("small/gap", 32'(bus_s.m_valid), 32'd1);
            end
            @(negedge clk);
            cyc++;
        end
        bus_s.m_ready = 1'b0;
        check("small/count", 32'(k), 32'(S_R * S_C));
        check("small/idle_ready", 32'(bus_s.frame_ready), 32'd1);
        check("small/idle_valid", 32'(bus_s.m_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_out_reader.md
CONV_OUT_READER -- requirements
Module: conv_out_reader

Interface
REQ-001 Parameter PIX_W, default 2: bits per output pixel.
REQ-002 Parameter ROWS, default 10: output rows per frame.
REQ-003 Parameter COLS, default 10: output columns per frame.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 frame_valid  input  1  a result frame is present on frame_data.
REQ-007 frame_ready  output  1  the block will accept a frame this cycle.
REQ-008 frame_data  input  ROWS*COLS*PIX_W  flat result frame; pixel (r,c) occupies bits [PIX_W*(COLS*r+c) +: PIX_W].
REQ-009 m_valid  output  1  m_data/m_row/m_col/m_last_* are valid.
REQ-010 m_ready  input  1  downstream accepts the current pixel.
REQ-011 m_data  output  PIX_W  current pixel value.
REQ-012 m_row  output  max(1,clog2(ROWS))  row index of the current pixel.
REQ-013 m_col  output  max(1,clog2(COLS))  column index of the current pixel.
REQ-014 m_last_col  output  1  the current pixel is the last column of its row.
REQ-015 m_last_frame  output  1  the current pixel is (ROWS-1, COLS-1).
REQ-016 busy  output  1  a frame is held and not fully drained.

Function
REQ-017 The block SHALL implement two states: IDLE and STREAM.
REQ-018 In IDLE, frame_ready SHALL be 1, and m_valid and busy SHALL be 0.
REQ-019 A frame handshake (frame_valid && frame_ready in IDLE) SHALL register all of frame_data into an internal buffer, set row=0 and col=0, and move to STREAM.
REQ-020 In STREAM, frame_ready SHALL be 0, and m_valid and busy SHALL be 1.
REQ-021 Latency: the first pixel SHALL appear with m_valid=1 in the cycle after the frame handshake.
REQ-022 Pixels SHALL be emitted in row-major order: (0,0), (0,1) … (0,COLS-1), (1,0) … (ROWS-1,COLS-1).
REQ-023 m_data SHALL equal the buffered bits for (m_row,m_col), so later changes on frame_data have no effect.
REQ-024 While m_valid && !m_ready, m_data, m_row, m_col and both last flags SHALL hold stable.
REQ-025 On m_valid && m_ready, col SHALL increment; at col=COLS-1, col SHALL wrap to 0 and row SHALL increment.
REQ-026 m_last_col SHALL be 1 exactly when col=COLS-1.
REQ-027 m_last_frame SHALL be 1 exactly when row=ROWS-1 and col=COLS-1.
REQ-028 A handshake on the last-frame pixel SHALL return the block to IDLE, with frame_ready=1 in the next cycle (one bubble cycle between frames).
REQ-029 frame_valid while in STREAM SHALL be ignored; the buffer SHALL stay unchanged and frame_valid need not be held by design.
REQ-030 m_ready while in IDLE SHALL have no effect.
REQ-031 Exactly ROWS*COLS output handshakes SHALL occur per accepted frame: no drops, no duplicates.
REQ-032 With m_ready tied high, a frame SHALL drain in ROWS*COLS consecutive cycles.
REQ-033 m_data SHALL be 0 whenever m_valid=0.
REQ-034 m_row, m_col and the last flags SHALL be 0 whenever m_valid=0.

Reset
REQ-035 rst_n=0 SHALL immediately force IDLE, the buffer to all-zero, row=col=0, m_valid=0, busy=0, m_data=0, m_last_col=0 and m_last_frame=0, independent of clk.
REQ-036 During reset, frame_ready SHALL be 0.
REQ-037 frame_ready SHALL become 1 on the first rising clk edge after rst_n deasserts.
REQ-038 Reset asserted mid-frame SHALL discard the remaining pixels; no partial frame resumes after reset.

Verification
REQ-039 Reset, then a frame with pixel (r,c) = (r+c) mod 4, m_ready=1 -> 100 consecutive m_valid cycles; m_data matches per index; m_last_col pulses at col 9 of each row; m_last_frame only at (9,9); frame_ready=1 one cycle later.
REQ-040 Same frame, m_ready toggled pseudo-randomly (~50%) -> identical 100-pixel sequence; outputs stable during every stall.
REQ-041 frame_valid held high with a second frame of all-3 during the streaming of a first frame of all-1 -> 100 pixels of value 1, then the second frame accepted in the IDLE cycle and 100 pixels of value 3.
REQ-042 rst_n pulsed low after 37 accepted pixels -> m_valid=0 asynchronously; after release, frame_ready=1 and a new frame streams from (0,0).
REQ-043 Single-pixel frame bits: only (4,7)=2, all others 0 -> pixel 47 in output order reads 2, all others 0.
REQ-044 Parameter override ROWS=3, COLS=5, PIX_W=4 -> 15 pixels; m_row and m_col are 2 bits and 3 bits wide; m_last_col at col 4.
